// File: rtl/steer_en_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : steer_en_ctrl
// Purpose  : Rider detection and steering-enable controller. Paces A2D
//            conversions with a periodic nxt pulse and qualifies the summed
//            load-cell weight and balance before enabling steering.
// Options  : `STEER_DIFF_CHK_EN enables the left/right imbalance checks.
// Revision : 1.0 - initial release
// ============================================================================
module steer_en_ctrl #(
    parameter int          FAST_SIM     = 0,
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040,
    parameter int          NXT_PERIOD   = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        nxt,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int                 c_CNT_W   = $clog2(NXT_PERIOD);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NXT_PERIOD - 1);
    localparam logic [12:0]        c_ON_THR  = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0]        c_OFF_THR = {1'b0, MIN_RIDER_WT - WT_HYST};

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_STEER = 2'd2;

    logic [c_CNT_W-1:0] r_req_cnt;
    logic               r_nxt;
    logic [25:0]        r_tmr;
    logic [1:0]         r_state;
    logic [1:0]         w_nxt_state;
    logic               r_en_steer;
    logic               r_rider_off;
    logic               w_en_steer_d;
    logic               w_rider_off_d;
    logic               w_clr_tmr;
    logic               w_tmr_full;
    logic [12:0]        w_sum;
    logic               w_sum_gt_min;
    logic               w_sum_lt_min;
    logic               w_diff_gt_1_4;
    logic               w_diff_gt_15_16;

    // ---------------- conversion request generator ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_cnt <= '0;
            r_nxt     <= 1'b0;
        end else begin
            r_nxt     <= (r_req_cnt == c_CNT_LAST);
            r_req_cnt <= (r_req_cnt == c_CNT_LAST) ? '0 : r_req_cnt + 1'b1;
        end
    end

    // ---------------- weight arithmetic ----------------
    assign w_sum        = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign w_sum_gt_min = (w_sum > c_ON_THR);
    assign w_sum_lt_min = (w_sum < c_OFF_THR);

`ifdef STEER_DIFF_CHK_EN
    logic [11:0] w_diff;
    assign w_diff          = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
    assign w_diff_gt_1_4   = ({1'b0, w_diff} > (w_sum >> 2));
    assign w_diff_gt_15_16 = ({1'b0, w_diff} > (w_sum - (w_sum >> 4)));
`else
    assign w_diff_gt_1_4   = 1'b0;
    assign w_diff_gt_15_16 = 1'b0;
`endif

    // ---------------- balance timer (saturating) ----------------
    always_ff @(posedge clk) begin
        if (rst || w_clr_tmr) begin
            r_tmr <= '0;
        end else if (r_tmr != '1) begin
            r_tmr <= r_tmr + 26'd1;
        end
    end

    generate
        if (FAST_SIM != 0) begin : g_tmr_fast
            assign w_tmr_full = &r_tmr[14:0];
        end else begin : g_tmr_full
            assign w_tmr_full = &r_tmr;
        end
    endgenerate

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_en_steer  <= 1'b0;
            r_rider_off <= 1'b1;
        end else begin
            r_state     <= w_nxt_state;
            r_en_steer  <= w_en_steer_d;
            r_rider_off <= w_rider_off_d;
        end
    end

    // Weight loss beats imbalance, imbalance beats timer expiry.
    always_comb begin
        w_nxt_state = r_state;
        w_clr_tmr   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_sum_gt_min) begin
                    w_nxt_state = c_WAIT;
                    w_clr_tmr   = 1'b1;
                end
            end
            c_WAIT: begin
                if (w_sum_lt_min) begin
                    w_nxt_state = c_IDLE;
                end else if (w_diff_gt_1_4) begin
                    w_clr_tmr   = 1'b1;
                end else if (w_tmr_full) begin
                    w_nxt_state = c_STEER;
                end
            end
            c_STEER: begin
                if (w_sum_lt_min) begin
                    w_nxt_state = c_IDLE;
                end else if (w_diff_gt_15_16) begin
                    w_nxt_state = c_WAIT;
                    w_clr_tmr   = 1'b1;
                end
            end
            default: begin
                w_nxt_state = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_en_steer_d  = (w_nxt_state == c_STEER);
        w_rider_off_d = (w_nxt_state == c_IDLE);
    end

    assign nxt       = r_nxt;
    assign en_steer  = r_en_steer;
    assign rider_off = r_rider_off;

endmodule
`default_nettype wire

// File: tb/tb_steer_en_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_steer_en_ctrl
// Purpose  : Scoreboard bench for steer_en_ctrl (FAST_SIM build); expected
//            outputs come from a behavioural model of the controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_steer_en_ctrl;

    localparam int c_PERIOD = 2048;
    localparam int c_TMR_N  = 32768;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        nxt;
    logic        en_steer;
    logic        rider_off;

    always #5 clk = ~clk;

    steer_en_ctrl #(
        .FAST_SIM    (1),
        .MIN_RIDER_WT(12'h200),
        .WT_HYST     (12'h040),
        .NXT_PERIOD  (c_PERIOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .nxt      (nxt),
        .en_steer (en_steer),
        .rider_off(rider_off)
    );

    typedef struct packed {
        logic nxt;
        logic en;
        logic off;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // behavioural model state: 0 idle, 1 wait, 2 steer
    int   m_state = 0;
    int   m_tmr   = 0;
    int   m_cnt   = 0;
    logic m_nxt   = 1'b0;
    logic m_en    = 1'b0;
    logic m_off   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int sum, diff, ns;
        bit gt_min, lt_min, d14, d1516, full, clr;
        if (rst) begin
            m_state = 0; m_tmr = 0; m_cnt = 0;
            m_nxt = 1'b0; m_en = 1'b0; m_off = 1'b1;
            return;
        end
        m_nxt = (m_cnt == c_PERIOD - 1);
        m_cnt = (m_cnt == c_PERIOD - 1) ? 0 : m_cnt + 1;
        sum    = int'(lft_ld) + int'(rght_ld);
        diff   = (int'(lft_ld) > int'(rght_ld)) ? int'(lft_ld) - int'(rght_ld)
                                                 : int'(rght_ld) - int'(lft_ld);
        gt_min = sum > 'h200;
        lt_min = sum < 'h1C0;
`ifdef STEER_DIFF_CHK_EN
        d14    = diff > sum / 4;
        d1516  = diff > sum - sum / 16;
`else
        d14    = 1'b0;
        d1516  = 1'b0;
`endif
        full   = (m_tmr % c_TMR_N) == c_TMR_N - 1;
        ns  = m_state;
        clr = 1'b0;
        if (m_state == 0) begin
            if (gt_min) begin ns = 1; clr = 1'b1; end
        end else if (m_state == 1) begin
            if (lt_min) ns = 0;
            else if (d14) clr = 1'b1;
            else if (full) ns = 2;
        end else begin
            if (lt_min) ns = 0;
            else if (d1516) begin ns = 1; clr = 1'b1; end
        end
        if (clr) m_tmr = 0;
        else if (m_tmr != (1 << 26) - 1) m_tmr = m_tmr + 1;
        m_state = ns;
        m_en    = (ns == 2);
        m_off   = (ns == 0);
    endtask

    // One clock: model predicts, DUT output is popped and compared after the edge.
    task automatic tick();
        exp_t e;
        logic rst_at_edge;
        rst_at_edge = rst;
        model_step();
        e = '{nxt: m_nxt, en: m_en, off: m_off};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_nxt", nxt, e.nxt);
        chk("sb_en_steer", en_steer, e.en);
        chk("sb_rider_off", rider_off, e.off);
        if (!rst_at_edge) cyc++;
        if (cyc == 2048 || cyc == 4096 || cyc == 6144) chk("nxt_pulse", nxt, 1);
        if (cyc == 2049 || cyc == 4097 || cyc == 6145) chk("nxt_width", nxt, 0);
    endtask

    task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_rider_off", rider_off, 1);
        chk("rst_en_steer", en_steer, 0);
        chk("rst_nxt", nxt, 0);

        // balanced step-on right at release
        rst = 1'b0;
        set_ld(12'h180, 12'h180);
        tick();
        chk("step_on_rider_off", rider_off, 0);
        chk("step_on_en_steer", en_steer, 0);
        repeat (c_TMR_N - 1) tick();
        chk("steer_not_early", en_steer, 0);
        tick();
        chk("steer_rise", en_steer, 1);

        // extreme imbalance while steering
        set_ld(12'h3F0, 12'h000);
        tick();
`ifdef STEER_DIFF_CHK_EN
        chk("imbal_steer_en", en_steer, 0);
        chk("imbal_steer_off", rider_off, 0);
`else
        chk("imbal_steer_en", en_steer, 1);
`endif
        tick();

        // reset partway through the balance count
        set_ld(12'h180, 12'h180);
        repeat (2000) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_off", rider_off, 1);
        chk("mid_rst_en", en_steer, 0);
        rst = 1'b0;
        tick();
        chk("reentry_off", rider_off, 0);
        repeat (2000) tick();

        // imbalance in WAIT restarts the timer
        set_ld(12'h300, 12'h080);
        repeat (10) tick();
        chk("imbal_wait_off", rider_off, 0);
        set_ld(12'h180, 12'h180);
        repeat (c_TMR_N - 1) tick();
`ifdef STEER_DIFF_CHK_EN
        chk("restart_not_early", en_steer, 0);
`endif
        tick();
        chk("restart_rise", en_steer, 1);

        // hysteresis band and step-off
        set_ld(12'h0E8, 12'h0E8);
        tick();
        chk("hyst_1d0_hold", en_steer, 1);
        set_ld(12'h0E0, 12'h0E0);
        tick();
        chk("hyst_1c0_hold", en_steer, 1);
        set_ld(12'h0D8, 12'h0D8);
        tick();
        chk("step_off_en", en_steer, 0);
        chk("step_off_off", rider_off, 1);
        set_ld(12'h0F8, 12'h0F8);
        repeat (2) tick();
        chk("hyst_1f0_idle", rider_off, 1);
        set_ld(12'h100, 12'h100);
        tick();
        chk("thr_200_idle", rider_off, 1);
        set_ld(12'h101, 12'h100);
        tick();
        chk("thr_201_wait", rider_off, 0);
        set_ld(12'h000, 12'h000);
        repeat (3) tick();
        chk("zero_idle", rider_off, 1);

        chk("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
